// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback result stage.
// Source codes name the default five-way result mux used by the W stage.
package wb_pkg;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;
  localparam int SRC_MUL = 4;

  localparam int WB_NSRC = 5;
  localparam int WB_RD_W = 5;

endpackage

// File: rtl/wb_src_sel.sv
// Combinational result-source selector: picks one packed source word and its
// valid bit by select code, and reports whether the code names a real source.
module wb_src_sel #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 5,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic [SELW-1:0]       sel_i,
  input  logic [NSRC*WIDTH-1:0] d_i,
  input  logic [NSRC-1:0]       valid_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  output logic                  in_range_o
);

  // Out-of-range codes match no iteration and fall through to all-zero outputs.
  always_comb begin
    data_o     = '0;
    valid_o    = 1'b0;
    in_range_o = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_i == SELW'(i)) begin
        data_o     = d_i[i*WIDTH +: WIDTH];
        valid_o    = valid_i[i];
        in_range_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_result_stage.sv
// Registered writeback-result stage: selects a result source, stalls upstream
// while a multi-cycle source is not ready, and bounds that wait with a timeout.
//
// Handshake: a request is presented with InValidW=1 and is taken in any cycle
// where StallW=0; while StallW=1 upstream holds ResultSrcW/RdW/RegWriteW/InValidW.
module wb_result_stage
  import wb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NSRC    = WB_NSRC,
  parameter int SELW    = $clog2(NSRC),
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SELW-1:0]       ResultSrcW,
  input  logic [NSRC*WIDTH-1:0] d,
  input  logic [NSRC-1:0]       SrcValidW,
  input  logic                  InValidW,
  input  logic                  RegWriteW,
  input  logic [WB_RD_W-1:0]    RdW,
  output logic                  StallW,
  output logic                  WbValid,
  output logic                  WbWe,
  output logic [WB_RD_W-1:0]    WbRd,
  output logic [WIDTH-1:0]      ResultW,
  output logic                  WbErr,
  output wb_state_e             dbg_state_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  wb_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [SELW-1:0]      sel_q, sel_d;
  logic [WB_RD_W-1:0]   rd_q, rd_d;
  logic                 we_q, we_d;
  logic                 wbvalid_q, wbvalid_d;
  logic                 wbwe_q, wbwe_d;
  logic                 wberr_q, wberr_d;
  logic [WB_RD_W-1:0]   wbrd_q, wbrd_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 stall;

  logic [SELW-1:0]      sel_eff;
  logic [WIDTH-1:0]     src_data;
  logic                 src_valid;
  logic                 src_in_range;
  logic                 timeout_hit;

  // In WAIT the latched select drives the mux; the live select is ignored.
  assign sel_eff = (state_q == WB_WAIT) ? sel_q : ResultSrcW;

  wb_src_sel #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_src_sel (
    .sel_i      (sel_eff),
    .d_i        (d),
    .valid_i    (SrcValidW),
    .data_o     (src_data),
    .valid_o    (src_valid),
    .in_range_o (src_in_range)
  );

  // Counter saturates; the request times out when it is about to reach TIMEOUT-1,
  // so the whole request spans at most TIMEOUT cycles including the IDLE cycle.
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    we_d      = we_q;
    wbvalid_d = 1'b0;
    wbwe_d    = 1'b0;
    wberr_d   = 1'b0;
    wbrd_d    = wbrd_q;
    result_d  = result_q;
    stall     = 1'b0;

    unique case (state_q)
      WB_IDLE: begin
        if (InValidW) begin
          if (!src_in_range) begin
            result_d  = '0;
            wbvalid_d = 1'b1;
            wberr_d   = 1'b1;
          end else if (src_valid) begin
            result_d  = src_data;
            wbvalid_d = 1'b1;
            wbwe_d    = RegWriteW & (RdW != '0);
            wbrd_d    = RdW;
          end else begin
            stall   = 1'b1;
            sel_d   = ResultSrcW;
            rd_d    = RdW;
            we_d    = RegWriteW & (RdW != '0);
            cnt_d   = '0;
            state_d = WB_WAIT;
          end
        end
      end

      WB_WAIT: begin
        cnt_d = cnt_inc;
        if (src_valid) begin
          result_d  = src_data;
          wbvalid_d = 1'b1;
          wbwe_d    = we_q;
          wbrd_d    = rd_q;
          state_d   = WB_IDLE;
        end else if (timeout_hit) begin
          result_d  = '0;
          wbvalid_d = 1'b1;
          wberr_d   = 1'b1;
          state_d   = WB_IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= WB_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      wbvalid_q <= 1'b0;
      wbwe_q    <= 1'b0;
      wberr_q   <= 1'b0;
      wbrd_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      wbvalid_q <= wbvalid_d;
      wbwe_q    <= wbwe_d;
      wberr_q   <= wberr_d;
      wbrd_q    <= wbrd_d;
      result_q  <= result_d;
    end
  end

  assign StallW      = stall;
  assign WbValid     = wbvalid_q;
  assign WbWe        = wbwe_q;
  assign WbErr       = wberr_q;
  assign WbRd        = wbrd_q;
  assign ResultW     = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed bench for wb_result_stage (WIDTH=32, NSRC=5, TIMEOUT=8) with an
// expected-output queue and a one-line summary.
module tb_wb_result_stage;
  import wb_pkg::*;

  localparam int W  = 32;
  localparam int NS = 5;
  localparam int SW = 3;
  localparam int TO = 8;
  localparam int EW = 3 + 5 + W;

  logic              clk;
  logic              reset;
  logic [SW-1:0]     ResultSrcW;
  logic [NS*W-1:0]   d;
  logic [NS-1:0]     SrcValidW;
  logic              InValidW;
  logic              RegWriteW;
  logic [4:0]        RdW;
  logic              StallW;
  logic              WbValid;
  logic              WbWe;
  logic [4:0]        WbRd;
  logic [W-1:0]      ResultW;
  logic              WbErr;
  wb_state_e         dbg_state;

  logic [EW-1:0]     exp_q[$];
  logic [4:0]        m_rd;
  logic [W-1:0]      m_res;
  int                n_vec;
  int                n_err;

  wb_result_stage #(
    .WIDTH   (W),
    .NSRC    (NS),
    .SELW    (SW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ResultSrcW  (ResultSrcW),
    .d           (d),
    .SrcValidW   (SrcValidW),
    .InValidW    (InValidW),
    .RegWriteW   (RegWriteW),
    .RdW         (RdW),
    .StallW      (StallW),
    .WbValid     (WbValid),
    .WbWe        (WbWe),
    .WbRd        (WbRd),
    .ResultW     (ResultW),
    .WbErr       (WbErr),
    .dbg_state_o (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic v, input logic we, input logic err,
                          input logic [4:0] rd, input logic [W-1:0] res);
    exp_q.push_back({v, we, err, rd, res});
    m_rd  = rd;
    m_res = res;
  endtask

  // No completion this cycle: flags low, rd/result hold.
  task automatic push_idle();
    exp_q.push_back({1'b0, 1'b0, 1'b0, m_rd, m_res});
  endtask

  task automatic drive(input logic inv, input logic [SW-1:0] sel,
                       input logic [4:0] rd, input logic rwe);
    InValidW   = inv;
    ResultSrcW = sel;
    RdW        = rd;
    RegWriteW  = rwe;
    #1;
  endtask

  task automatic tick_check(input string tag);
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {WbValid, WbWe, WbErr, WbRd, ResultW}, e);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_rd  = '0;
    m_res = '0;
    reset = 1'b0;
    InValidW = 1'b0; ResultSrcW = '0; RdW = '0; RegWriteW = 1'b0;
    SrcValidW = '1;
    d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {WbValid, WbWe, WbErr, WbRd, ResultW}, '0);
    chk("rst_stall", StallW, 1'b0);
    chk("rst_state", dbg_state, WB_IDLE);
    reset = 1'b1;

    // back-to-back hits
    for (int i = 0; i < NS; i++) d[i*W +: W] = 32'h1000_0000 + i;
    for (int i = 0; i < NS; i++) begin
      drive(1'b1, SW'(i), 5'(i + 1), 1'b1);
      chk("b2b_stall", StallW, 1'b0);
      push_exp(1'b1, 1'b1, 1'b0, 5'(i + 1), 32'h1000_0000 + i);
      tick_check("b2b_out");
    end

    // x0 suppression
    d[0 +: W] = 32'hDEAD_BEEF;
    drive(1'b1, 3'd0, 5'd0, 1'b1);
    chk("x0_stall", StallW, 1'b0);
    push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF);
    tick_check("x0_out");

    // idle cycle holds rd/result
    drive(1'b0, 3'd2, 5'd9, 1'b1);
    push_idle();
    tick_check("idle_hold");

    // multi-cycle source: 3 stalled cycles then valid
    SrcValidW[4] = 1'b0;
    d[4*W +: W] = 32'h0000_0042;
    drive(1'b1, 3'd4, 5'd7, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("mc_stall", StallW, 1'b1);
      push_idle();
      tick_check("mc_wait_out");
      chk("mc_state", dbg_state, WB_WAIT);
      drive(1'b1, 3'd2, 5'd9, 1'b0);
    end
    SrcValidW[4] = 1'b1;
    #1;
    chk("mc_release", StallW, 1'b0);
    push_exp(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0042);
    tick_check("mc_out");
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    push_idle();
    tick_check("mc_after");

    // timeout: stuck source
    SrcValidW[1] = 1'b0;
    drive(1'b1, 3'd1, 5'd3, 1'b1);
    for (int k = 0; k < TO - 1; k++) begin
      chk("to_stall", StallW, 1'b1);
      push_idle();
      tick_check("to_wait_out");
    end
    chk("to_release", StallW, 1'b0);
    push_exp(1'b1, 1'b0, 1'b1, m_rd, '0);
    tick_check("to_out");
    chk("to_state", dbg_state, WB_IDLE);
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    push_idle();
    tick_check("to_err_pulse");

    // valid arrives in the timeout cycle: data wins
    d[1*W +: W] = 32'hCAFE_0001;
    drive(1'b1, 3'd1, 5'd11, 1'b1);
    for (int k = 0; k < TO - 1; k++) begin
      chk("vt_stall", StallW, 1'b1);
      push_idle();
      tick_check("vt_wait_out");
    end
    SrcValidW[1] = 1'b1;
    #1;
    chk("vt_release", StallW, 1'b0);
    push_exp(1'b1, 1'b1, 1'b0, 5'd11, 32'hCAFE_0001);
    tick_check("vt_out");

    // out-of-range selects
    drive(1'b1, 3'd5, 5'd6, 1'b1);
    chk("oor5_stall", StallW, 1'b0);
    push_exp(1'b1, 1'b0, 1'b1, m_rd, '0);
    tick_check("oor5_out");
    drive(1'b1, 3'd7, 5'd6, 1'b1);
    chk("oor7_stall", StallW, 1'b0);
    push_exp(1'b1, 1'b0, 1'b1, m_rd, '0);
    tick_check("oor7_out");

    // reset in the middle of a wait
    SrcValidW[4] = 1'b0;
    drive(1'b1, 3'd4, 5'd12, 1'b1);
    push_idle();
    tick_check("rw_enter");
    chk("rw_state", dbg_state, WB_WAIT);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rw_outputs", {WbValid, WbWe, WbErr, WbRd, ResultW}, '0);
    chk("rw_state_idle", dbg_state, WB_IDLE);
    m_rd  = '0;
    m_res = '0;
    drive(1'b0, 3'd4, 5'd12, 1'b1);
    chk("rw_stall", StallW, 1'b0);
    push_idle();
    tick_check("rw_idle");
    SrcValidW = '1;
    d[2*W +: W] = 32'h0BAD_F00D;
    drive(1'b1, 3'd2, 5'd5, 1'b1);
    chk("rw_next_stall", StallW, 1'b0);
    push_exp(1'b1, 1'b1, 1'b0, 5'd5, 32'h0BAD_F00D);
    tick_check("rw_next_out");

    // random hits with all sources valid
    for (int n = 0; n < 20; n++) begin
      logic [2:0]   s;
      logic [4:0]   r;
      logic         we;
      logic [W-1:0] v;
      s  = 3'($urandom_range(0, NS - 1));
      r  = 5'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      v  = $urandom;
      d[s*W +: W] = v;
      drive(1'b1, s, r, we);
      chk("rnd_stall", StallW, 1'b0);
      push_exp(1'b1, we & (r != 5'd0), 1'b0, r, v);
      tick_check("rnd_out");
    end

    drive(1'b0, 3'd0, 5'd0, 1'b0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
